call_panel: RTL and testbench
=============================

// Module: call_panel
// PURPOSE
//   Request side of the elevator movement interface, for a 3-floor car.
//   - Debounces the three floor buttons and latches them as pending calls (led1..3).
//   - Clears a call when the movement controller reports service: car at that floor, door open, not moving.
//   - Runs a direction-preserving (collective) scheduler and presents the next target as goal_floor.
//   - goal_floor uses the codebase floor labels: 2'b00 = F1, 2'b01 = F2, 2'b10 = F3.
// PARAMETERS
//   DEBOUNCE_CYCLES  4  consecutive high samples required to accept a press; legal range 1..255
// PORTS
//   clk                    in   1  system clock; all state updates on its rising edge
//   button_reset           in   1  reset, synchronous, active-high
//   button1..button3       in   1  raw floor buttons, asynchronous, active-high
//   floor1..floor3         in   1  current-floor one-hot from the movement controller
//   door                   in   1  1 = door open
//   moving                 in   1  1 = car in motion
//   weight_limit_exceeded  in   1  1 = overload; new calls are blocked
//   led1..led3             out  1  pending call per floor (registered)
//   goal_floor             out  2  next target floor label (registered)
//   dir_up, dir_down       out  1  scheduler direction; both 0 = IDLE (registered)
//   call_pending           out  1  led1 | led2 | led3
// BEHAVIOUR
// - Reset (button_reset = 1 at a clock edge):
//     - led* = 0, goal_floor = 2'b00, dir_up = dir_down = 0.
//     - Debounce counters and debounced levels = 0; cur_idx = 0.
//     - Reset has priority over every other event, including mid-debounce and mid-trip.
// - Debounce, per button:
//     - 8-bit counter counts consecutive high samples; any low sample clears it to 0.
//     - The debounced level rises on the edge that samples the DEBOUNCE_CYCLES-th consecutive high.
//       A 0->1 change of the debounced level is one press event.
//     - Holding the button produces no further events. The debounced level falls on the first low sample.
// - Call latch, per floor n:
//     - svc_n = floorN & door & ~moving.
//     - A press event sets led_n on the same edge that raises the debounced level, unless blocked.
//     - A press is blocked if weight_limit_exceeded = 1, or if svc_n = 1.
//     - svc_n = 1 clears led_n. Press and svc_n on the same edge: clear wins.
//     - weight_limit_exceeded never clears existing calls.
// - Current floor (cur_idx):
//     - Registered from the one-hot floor inputs.
//     - If zero bits or more than one bit is set, the previous cur_idx is held.
// - Direction FSM: IDLE -> UP / DOWN, evaluated every edge from the registered leds and cur_idx.
//     - IDLE:
//         - No call: stay IDLE.
//         - Call above cur_idx: go UP. Otherwise, call below: go DOWN.
//         - Call only at cur_idx: stay IDLE.
//         - At F2 with calls at both F1 and F3: go UP.
//     - UP:
//         - goal = lowest pending floor above cur_idx.
//         - None above: go DOWN if any call is below, else go IDLE.
//     - DOWN: mirror of UP, using the highest pending floor below cur_idx.
//     - goal_floor = the chosen target. When no call applies, goal_floor = cur_idx.
//     - Latency: goal_floor and dir_* update one edge after the led/cur_idx change that caused them.
// - Labels: the value 2'b11 is never driven on goal_floor.
// CONFIGURATION
//   CALL_PANEL_CANCEL_EN
//     - Defined:
//         - A press event on a floor whose led is already lit clears that led (call cancel).
//         - Exception: no cancel when that floor equals goal_floor and moving = 1; the press is ignored.
//         - Cancel obeys the same weight_limit_exceeded blocking as a set.
//     - Undefined: a press on a lit floor has no effect.
// TESTING
//   1. Reset, then button2 high for 3 cycles (DEBOUNCE_CYCLES = 4) then low -> led2 stays 0.
//   2. Car at F1; button3 held 4 cycles -> led3 = 1 on the 4th edge.
//      One edge later: goal_floor = 2'b10, dir_up = 1, call_pending = 1.
//   3. Pending F3 call, car moving from F1 past F2; button2 pressed -> goal_floor = 2'b01.
//      Then floor2 = 1, door = 1, moving = 0 -> led2 cleared; next edge goal_floor = 2'b10.
//   4. Car at F2 idle; presses on button1 and button3 become lit on the same edge
//      -> dir_up = 1, goal_floor = 2'b10.
//   5. weight_limit_exceeded = 1 with led1 = 1; button3 pressed -> led3 stays 0, led1 stays 1.
//      button_reset pulse for 1 cycle -> all led* = 0, goal_floor = 2'b00, dir_* = 0.
//   6. With CALL_PANEL_CANCEL_EN, car idle at F1, led3 = 1, moving = 0;
//      second press on button3 -> led3 = 0, next edge dir_up = 0.
//      Without the macro, led3 stays 1.

Source files
------------

// File: rtl/call_panel.sv
// call_panel: debounced floor-call latch and collective up/down scheduler for a 3-floor car
// Optional build macro CALL_PANEL_CANCEL_EN: a second press on a lit floor cancels its call.
module call_panel #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       button_reset,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       floor1,
  input  logic       floor2,
  input  logic       floor3,
  input  logic       door,
  input  logic       moving,
  input  logic       weight_limit_exceeded,
  output logic       led1,
  output logic       led2,
  output logic       led3,
  output logic [1:0] goal_floor,
  output logic       dir_up,
  output logic       dir_down,
  output logic       call_pending
);
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
  state_t state, state_nx;
  logic [7:0] cnt [3];
  logic [7:0] cnt_nx [3];
  logic [2:0] btn, flr, svc, deb, deb_nx, press, led, led_nx;
  logic [1:0] cur_idx, cur_nx, goal_nx, up_goal, dn_goal;
  logic has_above, has_below, go_up, go_dn;
  assign btn = {button3, button2, button1};
  assign flr = {floor3, floor2, floor1};
  assign svc = flr & {3{door & ~moving}};
  assign press = deb_nx & ~deb;
  assign cur_nx = flr == 3'b001 ? 2'd0 : flr == 3'b010 ? 2'd1 : flr == 3'b100 ? 2'd2 : cur_idx;
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_nx[i] = btn[i] ? (cnt[i] == 8'hff ? cnt[i] : cnt[i] + 8'd1) : 8'd0;
      deb_nx[i] = btn[i] & (cnt_nx[i] >= 8'(DEBOUNCE_CYCLES));
`ifdef CALL_PANEL_CANCEL_EN
      // a lit floor toggles off, unless it is the floor the car is travelling to
      led_nx[i] = svc[i] ? 1'b0 : (press[i] & ~weight_limit_exceeded)
                ? (~led[i] | (goal_floor == 2'(i) && moving)) : led[i];
`else
      led_nx[i] = svc[i] ? 1'b0 : (press[i] & ~weight_limit_exceeded) ? 1'b1 : led[i];
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (button_reset) begin
      cnt <= '{default: 8'd0};
      deb <= '0;
      led <= '0;
      cur_idx <= 2'd0;
    end else begin
      cnt <= cnt_nx;
      deb <= deb_nx;
      led <= led_nx;
      cur_idx <= cur_nx;
    end
  end
  // nearest call in the current direction wins; a reversal only happens when none is left ahead
  assign has_above = (cur_idx == 2'd0 && (led[1] | led[2])) || (cur_idx == 2'd1 && led[2]);
  assign has_below = (cur_idx == 2'd2 && (led[1] | led[0])) || (cur_idx == 2'd1 && led[0]);
  assign up_goal = (cur_idx == 2'd0 && led[1]) ? 2'd1 : 2'd2;
  assign dn_goal = (cur_idx == 2'd2 && led[1]) ? 2'd1 : 2'd0;
  assign go_up = has_above & (state != DOWN | ~has_below);
  assign go_dn = has_below & ~go_up;
  always_comb begin
    state_nx = IDLE;
    goal_nx = cur_idx;
    state_nx = go_up ? UP : go_dn ? DOWN : IDLE;
    goal_nx = go_up ? up_goal : go_dn ? dn_goal : cur_idx;
  end
  always_ff @(posedge clk) begin
    if (button_reset) begin
      state <= IDLE;
      goal_floor <= 2'd0;
    end else begin
      state <= state_nx;
      goal_floor <= goal_nx;
    end
  end
  assign {led3, led2, led1} = led;
  assign dir_up = state == UP;
  assign dir_down = state == DOWN;
  assign call_pending = |led;
endmodule

// File: tb/tb_call_panel.sv
// tb_call_panel: directed checks of debounce, call latch, service clear and scheduler
module tb_call_panel;
  logic clk = 0, button_reset = 1;
  logic button1 = 0, button2 = 0, button3 = 0;
  logic floor1 = 0, floor2 = 0, floor3 = 0;
  logic door = 0, moving = 0, weight_limit_exceeded = 0;
  logic led1, led2, led3, dir_up, dir_down, call_pending;
  logic [1:0] goal_floor;
  int n_cmp = 0, n_bad = 0;
  call_panel #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .button_reset(button_reset),
    .button1(button1), .button2(button2), .button3(button3),
    .floor1(floor1), .floor2(floor2), .floor3(floor3),
    .door(door), .moving(moving), .weight_limit_exceeded(weight_limit_exceeded),
    .led1(led1), .led2(led2), .led3(led3), .goal_floor(goal_floor),
    .dir_up(dir_up), .dir_down(dir_down), .call_pending(call_pending)
  );
  always #5 clk = ~clk;
  task automatic tick(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    tick(2);
    button_reset = 0;
    chk("rst_leds", {led3, led2, led1}, 0);
    chk("rst_goal", goal_floor, 0);
    chk("rst_dir", {dir_up, dir_down}, 0);
    chk("rst_pending", call_pending, 0);
    floor1 = 1;
    button2 = 1;
    tick(3);
    button2 = 0;
    tick();
    chk("short_press_led2", led2, 0);
    button3 = 1;
    tick(3);
    chk("led3_before_4th", led3, 0);
    tick();
    chk("led3_on_4th", led3, 1);
    chk("goal_latency", goal_floor, 0);
    tick();
    chk("t2_goal", goal_floor, 2);
    chk("t2_dir_up", dir_up, 1);
    chk("t2_pending", call_pending, 1);
    button3 = 0;
    floor1 = 0;
    moving = 1;
    button2 = 1;
    tick(4);
    chk("t3_led2_set", led2, 1);
    button2 = 0;
    tick();
    chk("t3_goal_f2", goal_floor, 1);
    floor2 = 1;
    door = 1;
    moving = 0;
    tick();
    chk("t3_led2_clr", led2, 0);
    chk("t3_goal_hold", goal_floor, 1);
    tick();
    chk("t3_goal_f3", goal_floor, 2);
    chk("t3_dir_up", dir_up, 1);
    floor2 = 0;
    floor3 = 1;
    tick();
    chk("f3_served", led3, 0);
    tick();
    chk("f3_idle_dir", {dir_up, dir_down}, 0);
    chk("f3_idle_goal", goal_floor, 2);
    floor3 = 0;
    floor2 = 1;
    door = 0;
    tick();
    button1 = 1;
    button3 = 1;
    tick(4);
    chk("t4_leds", {led3, led1}, 3);
    tick();
    chk("t4_dir_up", {dir_up, dir_down}, 2);
    chk("t4_goal", goal_floor, 2);
    button1 = 0;
    button3 = 0;
    floor2 = 0;
    floor3 = 1;
    door = 1;
    tick();
    door = 0;
    floor3 = 0;
    floor2 = 1;
    tick();
    chk("t5_pre_led3", led3, 0);
    tick();
    chk("t5_dir_down", {dir_up, dir_down}, 1);
    chk("t5_goal_f1", goal_floor, 0);
    weight_limit_exceeded = 1;
    button3 = 1;
    tick(4);
    chk("t5_blocked_led3", led3, 0);
    chk("t5_kept_led1", led1, 1);
    button3 = 0;
    weight_limit_exceeded = 0;
    button_reset = 1;
    tick();
    button_reset = 0;
    chk("t5_rst_leds", {led3, led2, led1}, 0);
    chk("t5_rst_goal", goal_floor, 0);
    chk("t5_rst_dir", {dir_up, dir_down}, 0);
    floor2 = 0;
    floor1 = 1;
    tick();
    button3 = 1;
    tick(4);
    chk("t6_led3_set", led3, 1);
    button3 = 0;
    tick(2);
    chk("t6_dir_up", dir_up, 1);
    button3 = 1;
    tick(4);
`ifdef CALL_PANEL_CANCEL_EN
    chk("t6_cancel", led3, 0);
    tick();
    chk("t6_dir_after", dir_up, 0);
`else
    chk("t6_no_cancel", led3, 1);
    tick();
    chk("t6_dir_after", dir_up, 1);
`endif
    button3 = 0;
    door = 1;
    button1 = 1;
    tick(4);
    chk("svc_blocks_press", led1, 0);
    button1 = 0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
